mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared memory bus arbiter between instruction fetch and data access
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dbe,
    output logic [31:0] irdata,
    output logic [31:0] drdata,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [2:0] {IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE} stateT;

    stateT       state;
    logic        latchIreq;
    logic [31:0] latchIaddr;
    logic        latchDwe;

    // Bus address/data/enable registers double as the latched request copies;
    // they are only rewritten when a new bus request is launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            latchIreq  <= 1'b0;
            latchIaddr <= 32'd0;
            latchDwe   <= 1'b0;
            irdata     <= 32'd0;
            drdata     <= 32'd0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            bus_be     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    latchIreq  <= ireq;
                    latchIaddr <= iaddr;
                    latchDwe   <= dwe;
                    if (dreq) begin
                        state     <= D_REQ;
                        bus_req   <= 1'b1;
                        bus_we    <= dwe;
                        bus_addr  <= daddr;
                        bus_wdata <= dwdata;
                        bus_be    <= dbe;
                    end else if (ireq) begin
                        state    <= I_REQ;
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= iaddr;
                        bus_be   <= 4'b1111;
                    end
                end
                D_REQ: begin
                    if (bus_addr_ok) begin
                        state   <= D_WAIT;
                        bus_req <= 1'b0;
                    end
                end
                D_WAIT: begin
                    if (bus_data_ok) begin
                        if (!latchDwe) begin
                            drdata <= bus_rdata;
                        end
                        if (latchIreq) begin
                            state    <= I_REQ;
                            bus_req  <= 1'b1;
                            bus_we   <= 1'b0;
                            bus_addr <= latchIaddr;
                            bus_be   <= 4'b1111;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                I_REQ: begin
                    if (bus_addr_ok) begin
                        state   <= I_WAIT;
                        bus_req <= 1'b0;
                    end
                end
                I_WAIT: begin
                    if (bus_data_ok) begin
                        irdata <= bus_rdata;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // In IDLE the stall must rise in the same cycle the pipeline raises a request.
    always_comb begin
        mem_stall = 1'b0;
        case (state)
            IDLE:    mem_stall = ireq | dreq;
            DONE:    mem_stall = 1'b0;
            default: mem_stall = 1'b1;
        endcase
    end

endmodule
